// File: rtl/save_adder_if.sv
// save_adder_if: operand/result bundle for the carry-save adder; the master drives operands and the slave returns the sum.
interface save_adder_if #(parameter int WIDTH = 4);
   logic             in_valid;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic [WIDTH-1:0] z;
   logic             out_valid;
   logic [WIDTH:0]   s;
   logic             cout;
   modport master (output in_valid, x, y, z, input out_valid, s, cout);
   modport slave (input in_valid, x, y, z, output out_valid, s, cout);
endinterface

// File: rtl/save_adder.sv
// save_adder: registered three-operand carry-save adder, {cout,s} = x+y+z.
// Defining SAVE_ADDER_PIPE_EN registers the CSA outputs, giving 2-cycle latency.
module save_adder #(parameter int WIDTH = 4) (
   input logic clk,
   input logic rst_n,
   save_adder_if.slave bus
);
   logic [WIDTH-1:0] ps, c, ps_q, c_q;
   logic             v_q;
   logic [WIDTH:0]   pe, sum;
   logic             carry;
   assign ps = bus.x ^ bus.y ^ bus.z;
   assign c  = (bus.x & bus.y) | (bus.x & bus.z) | (bus.y & bus.z);
`ifdef SAVE_ADDER_PIPE_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ps_q <= '0;
         c_q  <= '0;
         v_q  <= 1'b0;
      end else begin
         v_q <= bus.in_valid;
         if (bus.in_valid) begin
            ps_q <= ps;
            c_q  <= c;
         end
      end
   end
`else
   assign ps_q = ps;
   assign c_q  = c;
   assign v_q  = bus.in_valid;
`endif
   assign pe = {1'b0, ps_q};
   // Carry vector is weighted one bit higher, so bit 0 of the sum is ps alone.
   always_comb begin
      sum    = '0;
      carry  = 1'b0;
      sum[0] = pe[0];
      for (int i = 1; i <= WIDTH; i++) begin
         sum[i] = pe[i] ^ c_q[i-1] ^ carry;
         carry  = (pe[i] & c_q[i-1]) | (carry & (pe[i] ^ c_q[i-1]));
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.s         <= '0;
         bus.cout      <= 1'b0;
         bus.out_valid <= 1'b0;
      end else begin
         bus.out_valid <= v_q;
         if (v_q) begin
            bus.s    <= sum;
            bus.cout <= carry;
         end
      end
   end
endmodule

// File: tb/tb_save_adder.sv
// tb_save_adder: randomized and exhaustive scoreboard bench for save_adder against plain x+y+z.
module tb_save_adder;
   localparam int WIDTH = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int tests = 0;
   int fails = 0;
   logic [WIDTH+1:0] q[$];
   logic [WIDTH+1:0] last = '0;
   logic [WIDTH+1:0] exp_v;
   logic [WIDTH+1:0] got;
   save_adder_if #(.WIDTH(WIDTH)) bus ();
   save_adder #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [WIDTH+1:0] act, input logic [WIDTH+1:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0d (cout=%b s=%b) expected %0d", name, act, act[WIDTH+1], act[WIDTH:0], req);
      end
   endtask
   task automatic drive(input logic v, input int a, input int b, input int d);
      @(negedge clk);
      bus.in_valid = v;
      bus.x = WIDTH'(a);
      bus.y = WIDTH'(b);
      bus.z = WIDTH'(d);
      if (v) q.push_back((WIDTH+2)'(a + b + d));
   endtask
   task automatic do_reset();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         rst_n = 1'b0;
         bus.in_valid = 1'($urandom);
         bus.x = WIDTH'($urandom);
         bus.y = WIDTH'($urandom);
         bus.z = WIDTH'($urandom);
         q.delete();
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus.in_valid = 1'b0;
   endtask
   always @(posedge clk) begin
      #1;
      got = {bus.cout, bus.s};
      if (!rst_n) begin
         check("reset_out_valid", {{(WIDTH+1){1'b0}}, bus.out_valid}, '0);
         check("reset_sum", got, '0);
         last = '0;
      end else if (bus.out_valid) begin
         if (q.size() == 0) begin
            check("unexpected_result", {{(WIDTH+1){1'b0}}, bus.out_valid}, '0);
         end else begin
            exp_v = q.pop_front();
            check("sum", got, exp_v);
            last = exp_v;
         end
      end else begin
         check("hold", got, last);
      end
   end
   initial begin
      int a[6] = '{2, 3, 10, 13, 4, 15};
      int b[6] = '{1, 2, 1, 9, 5, 15};
      int d[6] = '{4, 0, 2, 3, 8, 15};
      int n = 0;
      bus.in_valid = 1'b0;
      bus.x = '0;
      bus.y = '0;
      bus.z = '0;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, a[i], b[i], d[i]);
         drive(1'b0, 0, 0, 0);
         drive(1'b0, 0, 0, 0);
      end
      for (int i = 0; i < 20; i++) drive(1'b1, $urandom_range(15), $urandom_range(15), $urandom_range(15));
      for (int i = 0; i < 4; i++) drive(1'b0, $urandom_range(15), $urandom_range(15), $urandom_range(15));
      for (int i = 0; i < 200; i++) drive(1'($urandom), $urandom_range(15), $urandom_range(15), $urandom_range(15));
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            for (int k = 0; k < 16; k++) begin
               if (n == 2000) do_reset();
               drive(1'b1, i, j, k);
               n++;
            end
      for (int i = 0; i < 5; i++) drive(1'b0, 0, 0, 0);
      check("queue_drained", (WIDTH+2)'(q.size()), '0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
